// File: rtl/timer_counter.sv
`default_nettype none
// timer_counter: prescaled up/down timer with periodic or one-shot mode,
// terminal-count and compare pulses. Rev 1.0
module timer_counter #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr_b,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 oneshot,
  input  logic                 dir,
  input  logic [WIDTH-1:0]     period,
  input  logic [WIDTH-1:0]     cmp,
  input  logic [PSC_WIDTH-1:0] psc_div,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 cmp_match,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state, state_nxt;
  logic [WIDTH-1:0]     count_nxt;
  logic [WIDTH-1:0]     period_r, period_nxt;
  logic                 dir_r, dir_nxt;
  logic                 oneshot_r, oneshot_nxt;
  logic [PSC_WIDTH-1:0] psc_cnt, psc_nxt;
  logic                 tc_nxt, cmp_nxt;
  logic                 tick, terminal;

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      state     <= S_IDLE;
      count     <= '0;
      period_r  <= '0;
      dir_r     <= 1'b0;
      oneshot_r <= 1'b0;
      psc_cnt   <= '0;
      tc        <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      period_r  <= period_nxt;
      dir_r     <= dir_nxt;
      oneshot_r <= oneshot_nxt;
      psc_cnt   <= psc_nxt;
      tc        <= tc_nxt;
      cmp_match <= cmp_nxt;
    end
  end

  // >= rather than == so a psc_div lowered mid-run still produces a tick
  assign tick     = (psc_cnt >= psc_div);
  assign terminal = dir_r ? (count == period_r) : (count == '0);

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    period_nxt  = period_r;
    dir_nxt     = dir_r;
    oneshot_nxt = oneshot_r;
    psc_nxt     = psc_cnt;
    tc_nxt      = 1'b0;
    cmp_nxt     = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
      psc_nxt   = '0;
    end else if (start) begin
      period_nxt  = period;
      dir_nxt     = dir;
      oneshot_nxt = oneshot;
      psc_nxt     = '0;
      count_nxt   = dir ? '0 : period;
      state_nxt   = S_RUN;
    end else if (state == S_RUN) begin
      if (!tick) begin
        psc_nxt = psc_cnt + PSC_ONE;
      end else begin
        psc_nxt = '0;
        if (terminal) begin
          tc_nxt = 1'b1;
          if (oneshot_r) begin
            state_nxt = S_DONE;
          end else begin
            count_nxt = dir_r ? '0 : period_r;
          end
        end else begin
          count_nxt = dir_r ? (count + CNT_ONE) : (count - CNT_ONE);
        end
        cmp_nxt = (count_nxt == cmp);
      end
    end
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// tb_timer_counter: directed and randomized checks of timer_counter against
// a behavioural model. Rev 1.0
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       clr_b = 1'b0;
  logic       start = 1'b0, stop = 1'b0, oneshot = 1'b0, dir = 1'b1;
  logic [7:0] period = 8'd0, cmp = 8'd0;
  logic [3:0] psc_div = 4'd0;
  logic [7:0] count;
  logic       tc, cmp_match, busy, done;

  int checks = 0;
  int fails  = 0;

  // behavioural model state
  int m_count = 0, m_period = 0, m_elapsed = 0;
  bit m_up = 0, m_once = 0, m_run = 0, m_fin = 0, m_tc = 0, m_cm = 0;

  timer_counter #(.WIDTH(8), .PSC_WIDTH(4)) dut (
    .clk(clk), .clr_b(clr_b), .start(start), .stop(stop), .oneshot(oneshot),
    .dir(dir), .period(period), .cmp(cmp), .psc_div(psc_div),
    .count(count), .tc(tc), .cmp_match(cmp_match), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {count, tc, cmp_match, busy, done};

  function automatic logic [11:0] exp_vec();
    logic [7:0] c;
    c = m_count[7:0];
    return {c, m_tc, m_cm, m_run, m_fin};
  endfunction

  task automatic model_reset();
    m_count = 0; m_period = 0; m_elapsed = 0;
    m_up = 0; m_once = 0; m_run = 0; m_fin = 0; m_tc = 0; m_cm = 0;
  endtask

  // One rising edge of the timer's rules, from the inputs present at the edge.
  task automatic model_update();
    m_tc = 0;
    m_cm = 0;
    if (stop) begin
      m_run = 0; m_fin = 0; m_elapsed = 0;
    end else if (start) begin
      m_period = period; m_up = dir; m_once = oneshot; m_elapsed = 0;
      m_count = dir ? 0 : int'(period);
      m_run = 1; m_fin = 0;
    end else if (m_run) begin
      if (m_elapsed < int'(psc_div)) begin
        m_elapsed++;
      end else begin
        m_elapsed = 0;
        if (m_count == (m_up ? m_period : 0)) begin
          m_tc = 1;
          if (m_once) begin
            m_run = 0; m_fin = 1;
          end else begin
            m_count = m_up ? 0 : m_period;
          end
        end else begin
          m_count = (m_count + (m_up ? 1 : -1)) & 255;
        end
        m_cm = (m_count == int'(cmp));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: observed %h expected %h", obs, 12'h000);
    end
    @(negedge clk);
    clr_b = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL idle_after_reset: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_up_periodic();
    logic [7:0] exp_cnt [5];
    logic       exp_tc  [5];
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dir = 1'b1; oneshot = 1'b0; period = 8'd3; psc_div = 4'd0; cmp = 8'd200;
    start = 1'b1;
    step();
    checks++;
    if (obs !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL up_start_load: observed %h expected %h", obs, {8'd0, 4'b0010});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i] || obs !== exp_vec()) begin
        fails++;
        $display("FAIL up_periodic: cycle %0d observed count %0d tc %b required count %0d tc %b",
                 i, count, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL up_periodic_long: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_down_oneshot();
    dir = 1'b0; oneshot = 1'b1; period = 8'd5; psc_div = 4'd2; cmp = 8'd3;
    start = 1'b1;
    step();
    for (int i = 0; i < 22; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL down_oneshot: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL down_oneshot_done: observed count %0d done %b busy %b required 0 1 0",
               count, done, busy);
    end
  endtask

  task automatic test_cmp();
    dir = 1'b1; oneshot = 1'b0; period = 8'd4; psc_div = 4'd0; cmp = 8'd0;
    start = 1'b1;
    step();
    checks++;
    if (cmp_match !== 1'b0) begin
      fails++;
      $display("FAIL cmp_not_on_load: observed %b required 0", cmp_match);
    end
    cmp = 8'd2;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (cmp_match !== (count == 8'd2) || obs !== exp_vec()) begin
        fails++;
        $display("FAIL cmp_match: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_start_stop();
    logic [7:0] held;
    dir = 1'b1; oneshot = 1'b0; period = 8'd9; psc_div = 4'd0; cmp = 8'd50;
    start = 1'b1;
    step();
    repeat (4) step();
    held = count;
    start = 1'b1; stop = 1'b1;
    step();
    checks++;
    if (count !== held || busy !== 1'b0 || tc !== 1'b0 || cmp_match !== 1'b0 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL start_stop_same_edge: observed %h expected %h", obs, exp_vec());
    end
    start = 1'b1;
    step();
    repeat (3) step();
    dir = 1'b0; period = 8'd7;
    start = 1'b1;
    step();
    checks++;
    if (count !== 8'd7 || busy !== 1'b1 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL restart_reload: observed %h expected %h", obs, exp_vec());
    end
    step();
    checks++;
    if (count !== 8'd6 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL restart_first_tick: observed %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    dir = 1'b1; oneshot = 1'b0; period = 8'd2; psc_div = 4'd0; cmp = 8'd1;
    start = 1'b1;
    step();
    step();
    #2 clr_b = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      fails++;
      $display("FAIL async_reset: observed %h expected %h", obs, 12'h000);
    end
    model_reset();
    #1 clr_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (tc !== 1'b0 || obs !== exp_vec()) begin
        fails++;
        $display("FAIL after_async_reset: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    dir = 1'b1; oneshot = 1'b0; period = 8'd255; psc_div = 4'd0; cmp = 8'd255;
    start = 1'b1;
    step();
    repeat (254) step();
    checks++;
    if (count !== 8'd254 || tc !== 1'b0) begin
      fails++;
      $display("FAIL wrap_254: observed count %0d tc %b required 254 0", count, tc);
    end
    step();
    checks++;
    if (count !== 8'd255 || tc !== 1'b0 || cmp_match !== 1'b1) begin
      fails++;
      $display("FAIL wrap_255: observed count %0d tc %b cm %b required 255 0 1", count, tc, cmp_match);
    end
    step();
    checks++;
    if (count !== 8'd0 || tc !== 1'b1 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL wrap_0: observed count %0d tc %b required 0 1", count, tc);
    end
    period = 8'd0; cmp = 8'd9;
    start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (count !== 8'd0 || tc !== 1'b1 || obs !== exp_vec()) begin
        fails++;
        $display("FAIL period_zero: cycle %0d observed count %0d tc %b required 0 1", i, count, tc);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if (start) begin
        dir     = $urandom_range(0, 1);
        oneshot = $urandom_range(0, 1);
        period  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 9) == 0) psc_div = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) cmp = 8'($urandom_range(0, 6));
      step();
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random: cycle %0d observed %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_periodic();
    test_down_oneshot();
    test_cmp();
    test_start_stop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter/period/compare width (legal 2..32).
REQ-002 SHALL have parameter PSC_WIDTH, default 8, prescaler width (legal 1..16).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk and clr_b.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 clr_b  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse: latch configuration, begin counting.
REQ-007 stop  input  1  one-cycle pulse: halt, go IDLE.
REQ-008 oneshot  input  1  1 = stop at terminal count; 0 = periodic auto-reload; latched on start.
REQ-009 dir  input  1  1 = up, 0 = down; latched on start.
REQ-010 period  input  WIDTH  terminal/reload value; latched on start into period_r.
REQ-011 cmp  input  WIDTH  compare value; live, not latched.
REQ-012 psc_div  input  PSC_WIDTH  prescale; tick every psc_div+1 clk cycles; live.
REQ-013 count  output  WIDTH  current count, registered.
REQ-014 tc  output  1  terminal-count pulse, registered.
REQ-015 cmp_match  output  1  compare pulse, registered.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; busy = (RUN), done = (DONE).
REQ-019 Priority each edge: stop > start > tick.
REQ-020 start (any state): period_r<=period, dir_r<=dir, oneshot_r<=oneshot, psc_cnt<=0, count<= (dir ? 0 : period), state<=RUN; no tc/cmp_match that edge.
REQ-021 stop (any state): state<=IDLE, count holds, psc_cnt<=0, tc/cmp_match 0.
REQ-022 RUN: tick = (psc_cnt >= psc_div); on tick psc_cnt<=0, else psc_cnt+1 (>= covers psc_div lowered mid-run).
REQ-023 Up tick: count==period_r -> tc=1; periodic: count<=0; oneshot: count holds, state<=DONE; else count<=count+1.
REQ-024 Down tick: count==0 -> tc=1; periodic: count<=period_r; oneshot: count holds 0, state<=DONE; else count<=count-1.
REQ-025 tc and cmp_match SHALL be high exactly one clk cycle, asserted at the tick edge causing the event, otherwise 0.
REQ-026 cmp_match=1 at a RUN tick edge whose new count value equals cmp; not on start load.
REQ-027 Latency: psc_div=0 -> first count change at first edge after start edge; psc_div=N -> at (N+1)th edge after start.
REQ-028 period_r=0: periodic gives tc every tick, count stays 0; oneshot enters DONE at first tick.
REQ-029 Arithmetic modulo 2^WIDTH; no overflow beyond terminal checks.
REQ-030 IDLE and DONE: count, psc_cnt frozen; no pulses; inputs other than start/stop ignored.

Reset
REQ-031 clr_b=0 SHALL immediately, independent of clk, force state IDLE, count 0, psc_cnt 0, period_r 0, dir_r 0, oneshot_r 0, tc 0, cmp_match 0, busy 0, done 0.
REQ-032 Reset mid-RUN SHALL abort without pulses; first active edge after clr_b rises behaves as IDLE.
REQ-033 clr_b deassertion is synchronous to clk at system level; block contains no reset synchronizer.

Verification
REQ-034 WIDTH=8, psc_div=0, dir=1, oneshot=0, period=3, start -> count 1,2,3,0,1 on successive edges; tc high the cycle count returns to 0, every 4 cycles.
REQ-035 dir=0, oneshot=1, period=5, psc_div=2 -> count decrements every 3 cycles 5..0; tc one cycle at entry to DONE with count 0, done=1, busy=0, count holds.
REQ-036 cmp=2, up periodic period=4 -> cmp_match one cycle each time count becomes 2; none at start when cmp=0 and count loads 0.
REQ-037 start and stop same edge during RUN -> IDLE, count held, no pulses; start alone during RUN -> restart from reload value.
REQ-038 clr_b pulsed low between clk edges mid-RUN -> all outputs 0 immediately; no tc afterwards until new start.
REQ-039 WIDTH=8, period=255 up periodic -> count 254,255,0 wrap with tc; period=0 periodic -> tc every tick, count 0.
